// File: rtl/servile_timer.sv
// RISC-V machine timer (mtime/mtimecmp) with prescaler, on a Wishbone slave port.
// Accesses complete one cycle after stb; the interrupt is a registered level compare.
module servile_timer #(
    parameter int unsigned PRESCALE_W    = 16,
    parameter int unsigned base_adr_bits = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_irq
);

    localparam int unsigned SEL_W = base_adr_bits - 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [63:0]           r_mtime;
    logic [63:0]           r_mtimecmp;
    logic [PRESCALE_W-1:0] r_presc;
    logic [PRESCALE_W-1:0] r_tcnt;
    logic [31:0]           r_rdt;
    logic                  r_irq;

    logic [SEL_W-1:0]      w_reg;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_tick;
    logic [63:0]           w_mtime_inc;
    logic [63:0]           w_mtime_nxt;
    logic [63:0]           w_cmp_nxt;
    logic [PRESCALE_W-1:0] w_presc_nxt;
    logic [PRESCALE_W-1:0] w_tcnt_nxt;
    logic [31:0]           w_rd;
    logic                  w_unused;

    // Byte-lane merge: selected lanes from new, the rest from old.
    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_reg       = i_wb_adr[base_adr_bits-1:2];
    assign w_acc       = i_wb_stb && (r_state == S_IDLE);
    assign w_wr        = w_acc && i_wb_we;
    assign w_tick      = (r_tcnt == r_presc);
    assign w_mtime_inc = r_mtime + 64'(w_tick);
    assign w_unused    = ^{i_wb_adr[31:base_adr_bits], i_wb_adr[1:0]};

    // Ack toggle: one access per stb, ack never held two cycles.
    always_comb begin
        w_state_nxt = S_IDLE;
        if ((r_state == S_IDLE) && i_wb_stb) begin
            w_state_nxt = S_ACK;
        end
    end

    // Register next values; a written word overrides only its selected bytes.
    always_comb begin
        w_mtime_nxt = w_mtime_inc;
        w_cmp_nxt   = r_mtimecmp;
        w_presc_nxt = r_presc;
        w_tcnt_nxt  = w_tick ? '0 : r_tcnt + PRESCALE_W'(1);
        if (w_wr) begin
            case (w_reg)
                SEL_W'(0): w_mtime_nxt[31:0]  = f_merge(w_mtime_inc[31:0], i_wb_dat, i_wb_sel);
                SEL_W'(1): w_mtime_nxt[63:32] = f_merge(w_mtime_inc[63:32], i_wb_dat, i_wb_sel);
                SEL_W'(2): w_cmp_nxt[31:0]    = f_merge(r_mtimecmp[31:0], i_wb_dat, i_wb_sel);
                SEL_W'(3): w_cmp_nxt[63:32]   = f_merge(r_mtimecmp[63:32], i_wb_dat, i_wb_sel);
                SEL_W'(4): begin
                    w_presc_nxt = PRESCALE_W'(f_merge(32'(r_presc), i_wb_dat, i_wb_sel));
                    w_tcnt_nxt  = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_reg)
            SEL_W'(0): w_rd = r_mtime[31:0];
            SEL_W'(1): w_rd = r_mtime[63:32];
            SEL_W'(2): w_rd = r_mtimecmp[31:0];
            SEL_W'(3): w_rd = r_mtimecmp[63:32];
            SEL_W'(4): w_rd = 32'(r_presc);
            default:   w_rd = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_presc    <= '0;
            r_tcnt     <= '0;
            r_rdt      <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            r_presc    <= w_presc_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_irq      <= (r_mtime >= r_mtimecmp);
            if (w_acc) begin
                r_rdt <= w_rd;
            end
        end
    end

    assign o_wb_ack = (r_state == S_ACK);
    assign o_wb_rdt = r_rdt;
    assign o_irq    = r_irq;

endmodule

// File: tb/tb_servile_timer.sv
// Bench for servile_timer: a cycle reference model pushes expected read data
// into a queue at each access; the bus task pops it when the ack appears.
module tb_servile_timer;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_irq;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];
    logic [31:0] last_rdt;

    logic [63:0] m_mtime, m_cmp, c_mt_n, c_cmp_n;
    logic [15:0] m_presc, m_tcnt, c_presc_n, c_tcnt_n;
    logic        m_ack, m_irq, c_acc, c_tick;
    logic [31:0] c_rv, c_word;

    servile_timer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wb_adr (i_wb_adr),
        .i_wb_dat (i_wb_dat),
        .i_wb_sel (i_wb_sel),
        .i_wb_we  (i_wb_we),
        .i_wb_stb (i_wb_stb),
        .o_wb_rdt (o_wb_rdt),
        .o_wb_ack (o_wb_ack),
        .o_irq    (o_irq)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] bmerge(input logic [31:0] old_v, input logic [31:0] dat,
                                           input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

    // Reference model of the timer behaviour
    always_comb begin
        c_acc     = i_wb_stb && !m_ack;
        c_tick    = (m_tcnt == m_presc);
        c_mt_n    = m_mtime + {63'd0, c_tick};
        c_cmp_n   = m_cmp;
        c_presc_n = m_presc;
        c_tcnt_n  = c_tick ? 16'd0 : m_tcnt + 16'd1;
        c_word    = 32'h0;
        c_rv      = 32'h0;
        case (i_wb_adr[4:2])
            3'd0: c_rv = m_mtime[31:0];
            3'd1: c_rv = m_mtime[63:32];
            3'd2: c_rv = m_cmp[31:0];
            3'd3: c_rv = m_cmp[63:32];
            3'd4: c_rv = {16'h0, m_presc};
            default: c_rv = 32'h0;
        endcase
        if (c_acc && i_wb_we) begin
            case (i_wb_adr[4:2])
                3'd0: c_mt_n[31:0]   = bmerge(c_mt_n[31:0], i_wb_dat, i_wb_sel);
                3'd1: c_mt_n[63:32]  = bmerge(c_mt_n[63:32], i_wb_dat, i_wb_sel);
                3'd2: c_cmp_n[31:0]  = bmerge(m_cmp[31:0], i_wb_dat, i_wb_sel);
                3'd3: c_cmp_n[63:32] = bmerge(m_cmp[63:32], i_wb_dat, i_wb_sel);
                3'd4: begin
                    c_word    = bmerge({16'h0, m_presc}, i_wb_dat, i_wb_sel);
                    c_presc_n = c_word[15:0];
                    c_tcnt_n  = 16'd0;
                end
                default: ;
            endcase
        end
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_mtime <= 64'd0;
            m_cmp   <= '1;
            m_presc <= 16'd0;
            m_tcnt  <= 16'd0;
            m_ack   <= 1'b0;
            m_irq   <= 1'b0;
        end else begin
            m_mtime <= c_mt_n;
            m_cmp   <= c_cmp_n;
            m_presc <= c_presc_n;
            m_tcnt  <= c_tcnt_n;
            m_ack   <= c_acc;
            m_irq   <= (m_mtime >= m_cmp);
            if (c_acc && !i_wb_we) exp_q.push_back(c_rv);
        end
    end

    task automatic do_reset();
        i_rst    = 1'b1;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
    endtask

    // One Wishbone access; on reads the ack pops the model's expected data
    task automatic bus(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input string name);
        logic        got;
        logic [31:0] exp_v;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_stb = 1'b1;
        got      = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge i_clk);
            #1;
            got = (o_wb_ack === 1'b1);
        end
        last_rdt = o_wb_rdt;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL %s: no ack within 8 cycles", name);
        end else if (!we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s: ack with no expected read queued, rdt=%h", name, o_wb_rdt);
            end else begin
                exp_v = exp_q.pop_front();
                if (o_wb_rdt !== exp_v) begin
                    n_errors++;
                    $display("FAIL %s: rdt=%h expected %h", name, o_wb_rdt, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_wb_ack !== 1'b0 || o_irq !== 1'b0 || o_wb_rdt !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: ack=%b irq=%b rdt=%h expected 0 0 0", o_wb_ack, o_irq, o_wb_rdt);
        end
        bus(32'h08, 32'h0, 4'hF, 1'b0, "reset_cmp_lo");
        n_checks++;
        if (last_rdt !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL reset_cmp_lo_ones: got %h expected ffffffff", last_rdt);
        end
        bus(32'h0C, 32'h0, 4'hF, 1'b0, "reset_cmp_hi");
        bus(32'h10, 32'h0, 4'hF, 1'b0, "reset_prescale");
        n_checks++;
        if (last_rdt !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_prescale_zero: got %h expected 0", last_rdt);
        end
    endtask

    task automatic test_irq();
        int first;
        do_reset();
        bus(32'h0C, 32'h0, 4'hF, 1'b1, "irq_cmp_hi_wr");
        bus(32'h08, 32'h5, 4'hF, 1'b1, "irq_cmp_lo_wr");
        bus(32'h00, 32'h0, 4'hF, 1'b1, "irq_mtime_clr");
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge i_clk);
            #1;
            n_checks++;
            if (o_irq !== m_irq) begin
                n_errors++;
                $display("FAIL irq_cycle%0d: irq=%b expected %b", k, o_irq, m_irq);
            end
            if (o_irq === 1'b1 && first == 0) first = k;
        end
        n_checks++;
        if (first != 6) begin
            n_errors++;
            $display("FAIL irq_latency: rose after %0d cycles expected 6", first);
        end
        bus(32'h0C, 32'h1, 4'hF, 1'b1, "irq_cmp_raise");
        @(posedge i_clk);
        #1;
        n_checks++;
        if (o_irq !== 1'b0 || m_irq !== 1'b0) begin
            n_errors++;
            $display("FAIL irq_clear: irq=%b model=%b expected 0", o_irq, m_irq);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] a;
        do_reset();
        bus(32'h10, 32'h3, 4'hF, 1'b1, "presc_wr");
        bus(32'h00, 32'h0, 4'hF, 1'b0, "presc_rd_a");
        a = last_rdt;
        repeat (40) @(posedge i_clk);
        #1;
        bus(32'h00, 32'h0, 4'hF, 1'b0, "presc_rd_b");
        n_checks++;
        if ((last_rdt - a) < 32'd9 || (last_rdt - a) > 32'd11) begin
            n_errors++;
            $display("FAIL presc_rate: delta=%0d expected 10", last_rdt - a);
        end
        bus(32'h10, 32'h0, 4'hF, 1'b0, "presc_rd_reg");
    endtask

    task automatic test_carry();
        do_reset();
        bus(32'h04, 32'h0, 4'hF, 1'b1, "carry_hi_wr");
        bus(32'h00, 32'hFFFF_FFFF, 4'hF, 1'b1, "carry_lo_wr");
        bus(32'h04, 32'h0, 4'hF, 1'b0, "carry_hi_rd");
        n_checks++;
        if (last_rdt !== 32'h1) begin
            n_errors++;
            $display("FAIL carry_hi_one: got %h expected 1", last_rdt);
        end
        bus(32'h00, 32'h0, 4'hF, 1'b0, "carry_lo_rd");
    endtask

    task automatic test_bytesel();
        do_reset();
        bus(32'h00, 32'h0, 4'hF, 1'b1, "bsel_clr");
        bus(32'h00, 32'h0000_AB00, 4'b0010, 1'b1, "bsel_wr");
        bus(32'h00, 32'h0, 4'hF, 1'b0, "bsel_rd_lo");
        n_checks++;
        if (last_rdt[31:8] !== 24'h0000AB) begin
            n_errors++;
            $display("FAIL bsel_bytes: got %h expected 0000ab in [31:8]", last_rdt);
        end
        bus(32'h04, 32'h0, 4'hF, 1'b0, "bsel_rd_hi");
    endtask

    task automatic test_unmapped();
        logic        exp_ack;
        logic [31:0] exp_v;
        do_reset();
        @(posedge i_clk);
        #1;
        i_wb_adr = 32'h1C;
        i_wb_we  = 1'b0;
        i_wb_sel = 4'hF;
        i_wb_stb = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge i_clk);
            #1;
            exp_ack = (c == 1 || c == 3);
            n_checks++;
            if (o_wb_ack !== exp_ack) begin
                n_errors++;
                $display("FAIL unmapped_ack_c%0d: ack=%b expected %b", c, o_wb_ack, exp_ack);
            end
            if (o_wb_ack === 1'b1) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (o_wb_rdt !== 32'h0 || exp_v !== 32'h0) begin
                    n_errors++;
                    $display("FAIL unmapped_rdt_c%0d: rdt=%h model=%h expected 0", c, o_wb_rdt, exp_v);
                end
            end
        end
        i_wb_stb = 1'b0;
        bus(32'h1C, 32'hFFFF_FFFF, 4'hF, 1'b1, "unmapped_wr");
        bus(32'h10, 32'h0, 4'hF, 1'b0, "unmapped_presc");
        n_checks++;
        if (last_rdt !== 32'h0) begin
            n_errors++;
            $display("FAIL unmapped_presc_kept: got %h expected 0", last_rdt);
        end
        bus(32'h08, 32'h0, 4'hF, 1'b0, "unmapped_cmp_lo");
        bus(32'h0C, 32'h0, 4'hF, 1'b0, "unmapped_cmp_hi");
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(posedge i_clk);
        #1;
        i_rst    = 1'b1;
        i_wb_adr = 32'h08;
        i_wb_dat = 32'h0;
        i_wb_sel = 4'hF;
        i_wb_we  = 1'b1;
        i_wb_stb = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge i_clk);
            #1;
            n_checks++;
            if (o_wb_ack !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_ack_c%0d: ack=%b expected 0", c, o_wb_ack);
            end
        end
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        i_rst    = 1'b0;
        exp_q.delete();
        bus(32'h08, 32'h0, 4'hF, 1'b0, "abort_cmp_lo");
        n_checks++;
        if (last_rdt !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL abort_cmp_ones: got %h expected ffffffff", last_rdt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus(32'h10, 32'h0000_0001, 4'b0001, 1'b1, "b2b_presc_wr");
        bus(32'h08, 32'h1234_5678, 4'b1001, 1'b1, "b2b_cmp_lo_wr");
        for (int r = 0; r < 8; r++) begin
            bus(32'(r * 4), 32'h0, 4'h0, 1'b0, $sformatf("b2b_rd%0d", r));
        end
    endtask

    initial begin
        i_clk    = 1'b0;
        i_rst    = 1'b1;
        i_wb_adr = 32'h0;
        i_wb_dat = 32'h0;
        i_wb_sel = 4'h0;
        i_wb_we  = 1'b0;
        i_wb_stb = 1'b0;
        n_checks = 0;
        n_errors = 0;
        last_rdt = 32'h0;
        test_reset();
        test_irq();
        test_prescale();
        test_carry();
        test_bytesel();
        test_unmapped();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/servile_timer.md
SERVILE_TIMER -- requirements
Module: servile_timer

Interface
REQ-001 Parameter: PRESCALE_W, default 16, width of the prescaler divide register and its counter (1..32).
REQ-002 Parameter: base_adr_bits, default 5, number of low address bits decoded (i_wb_adr[4:2] selects the register).
REQ-003 Port: i_clk  input  1  single clock for all logic.
REQ-004 Port: i_rst  input  1  synchronous, active-high reset.
REQ-005 Port: i_wb_adr  input  32  Wishbone address from the servile extension bus.
REQ-006 Port: i_wb_dat  input  32  Wishbone write data.
REQ-007 Port: i_wb_sel  input  4  byte enables; bit n covers dat[8n+7:8n].
REQ-008 Port: i_wb_we  input  1  write strobe qualifier.
REQ-009 Port: i_wb_stb  input  1  cycle request, held by master until ack.
REQ-010 Port: o_wb_rdt  output  32  read data, valid when o_wb_ack=1.
REQ-011 Port: o_wb_ack  output  1  single-cycle acknowledge.
REQ-012 Port: o_irq  output  1  timer interrupt, drives servile i_timer_irq.

Function
REQ-013 Register map (adr[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 PRESCALE (low PRESCALE_W bits, upper bits read 0); 5-7 unmapped.
REQ-014 Handshake: o_wb_ack SHALL be registered, o_wb_ack <= i_wb_stb & !o_wb_ack; one access per stb, ack asserts exactly 1 cycle after stb is first seen, deasserts the following cycle.
REQ-015 Write takes effect on the cycle ack is asserted (same edge ack goes high), only for bytes with i_wb_sel set; unmapped writes SHALL be ignored.
REQ-016 o_wb_rdt SHALL be registered, captured at the same edge as ack, reflecting register value before any same-cycle update; unmapped reads return 32'h0; i_wb_sel ignored on reads.
REQ-017 Prescaler: tick counter counts 0..PRESCALE, wrapping to 0; tick=1 when counter==PRESCALE; PRESCALE=0 gives a tick every cycle.
REQ-018 Writing PRESCALE SHALL clear the tick counter at the same edge.
REQ-019 MTIME: 64-bit counter, increments by 1 on each tick, wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 without side effects.
REQ-020 Carry from MTIME_LO into MTIME_HI SHALL occur on the same edge as the low-word wrap.
REQ-021 Write to MTIME_LO/HI coincident with a tick: written bytes take the written value, unwritten bytes of that word take their incremented value; the other word is incremented normally including carry.
REQ-022 o_irq SHALL be registered: o_irq <= (MTIME >= MTIMECMP), unsigned 64-bit compare on current register values; 1-cycle latency after either operand changes.
REQ-023 o_irq is level; cleared only by raising MTIMECMP or lowering MTIME above/below the compare point.
REQ-024 No FSM beyond the 2-state ack toggle (IDLE: ack=0; ACK: ack=1 -> always IDLE next).

Reset
REQ-025 On i_rst=1 at a clock edge: MTIME=0, MTIMECMP=64'hFFFF_FFFF_FFFF_FFFF, PRESCALE=0, tick counter=0, o_wb_ack=0, o_wb_rdt=0, o_irq=0.
REQ-026 Reset during a bus cycle SHALL abort it: no ack, no write; master re-issues after reset.
REQ-027 Register values SHALL be defined only after the first reset edge; no initial values required.

Verification
REQ-028 Reset, PRESCALE=0, MTIMECMP_LO=5, MTIMECMP_HI=0 -> o_irq rises exactly 1 cycle after MTIME reaches 5.
REQ-029 Write PRESCALE=3, idle -> MTIME increments once every 4 cycles; read MTIME_LO after 40 cycles returns 10 (+/-1 for access latency, checked against model).
REQ-030 Write MTIME_LO=32'hFFFF_FFFF, MTIME_HI=0, PRESCALE=0 -> next tick reads MTIME_HI=1, MTIME_LO=0.
REQ-031 Write MTIME_LO with i_wb_sel=4'b0010, dat=32'h0000_AB00 -> only byte 1 changes; other bytes keep/increment per REQ-021.
REQ-032 stb held 4 cycles to adr 0x1C -> ack pulses at cycles 1 and 3, rdt=0, no register changes.
REQ-033 Assert i_rst during stb with we=1 to MTIMECMP_LO -> no ack, MTIMECMP reads all ones after reset.
